// File: rtl/uart_pkg.sv
// ============================================================
// Module   : uart_pkg
// Brief    : Shared UART constants, FSM state types and helpers.
// Revision : 1.0 - initial release
// ============================================================
`default_nettype none

package uart_pkg;

    localparam int c_PARITY_NONE = 0;
    localparam int c_PARITY_ODD  = 1;
    localparam int c_PARITY_EVEN = 2;

    typedef enum logic [2:0] {
        TX_IDLE   = 3'd0,
        TX_START  = 3'd1,
        TX_DATA   = 3'd2,
        TX_PARITY = 3'd3,
        TX_STOP   = 3'd4
    } tx_state_t;

    typedef enum logic [2:0] {
        RX_IDLE      = 3'd0,
        RX_START     = 3'd1,
        RX_DATA      = 3'd2,
        RX_PARITY    = 3'd3,
        RX_STOP      = 3'd4,
        RX_WAIT_HIGH = 3'd5
    } rx_state_t;

    // Clocks per 16x oversampling tick, rounded to nearest.
    function automatic int calc_div(input int clock_rate, input int baud_rate);
        int div;
        div = (clock_rate + 8 * baud_rate) / (16 * baud_rate);
        return (div < 1) ? 1 : div;
    endfunction

    function automatic logic parity_bit(input logic data_xor, input int mode);
        return (mode == c_PARITY_ODD) ? ~data_xor : data_xor;
    endfunction

endpackage

`default_nettype wire

// File: rtl/uart_baud_tick.sv
// ============================================================
// Module   : uart_baud_tick
// Brief    : Divide-by-DIV tick generator with synchronous clear.
// Revision : 1.0 - initial release
// ============================================================
`default_nettype none

module uart_baud_tick #(
    parameter int DIV = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    output logic o_tick
);

    localparam int                 c_CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DIV - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

    assign o_tick = (r_cnt == c_LAST);

endmodule

`default_nettype wire

// File: rtl/uart_core.sv
// ============================================================
// Module   : uart_core
// Brief    : Full-duplex UART, 16x oversampled receiver.
// Revision : 1.0 - initial release
// ============================================================
`default_nettype none

module uart_core
    import uart_pkg::*;
#(
    parameter int CLOCK_RATE = 100000000,
    parameter int BAUD_RATE  = 9600,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 i_Clk,
    input  logic                 i_Rst,
    input  logic [DATA_BITS-1:0] i_Tx_Data,
    input  logic                 i_Tx_Valid,
    output logic                 o_Tx_Ready,
    output logic                 o_Tx,
    input  logic                 i_Rx,
    output logic [DATA_BITS-1:0] o_Rx_Data,
    output logic                 o_Rx_Valid,
    output logic                 o_Parity_Err,
    output logic                 o_Frame_Err
);

    localparam int         c_DIV        = calc_div(CLOCK_RATE, BAUD_RATE);
    localparam logic [3:0] c_LAST_TICK  = 4'd15;
    localparam logic [3:0] c_MID_TICK   = 4'd7;
    localparam logic [3:0] c_LAST_DATA  = 4'(DATA_BITS - 1);
    localparam logic [3:0] c_LAST_STOP  = 4'(STOP_BITS - 1);
    localparam bit         c_HAS_PARITY = (PARITY != c_PARITY_NONE);

    // ---------------- transmitter ----------------
    tx_state_t            r_tx_state, w_tx_state_nxt;
    logic [DATA_BITS-1:0] r_tx_shift, w_tx_shift_nxt;
    logic [3:0]           r_tx_ticks, w_tx_ticks_nxt;
    logic [3:0]           r_tx_idx,   w_tx_idx_nxt;
    logic                 r_tx_par,   w_tx_par_nxt;
    logic                 r_tx_line,  w_tx_line_nxt;
    logic                 w_tx_clear, w_tx_tick, w_tx_bit_end;

    uart_baud_tick #(.DIV(c_DIV)) u_tx_tick (
        .clk     (i_Clk),
        .rst     (i_Rst),
        .i_clear (w_tx_clear),
        .o_tick  (w_tx_tick)
    );

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_shift <= '0;
            r_tx_ticks <= '0;
            r_tx_idx   <= '0;
            r_tx_par   <= 1'b0;
            r_tx_line  <= 1'b1;
        end else begin
            r_tx_state <= w_tx_state_nxt;
            r_tx_shift <= w_tx_shift_nxt;
            r_tx_ticks <= w_tx_ticks_nxt;
            r_tx_idx   <= w_tx_idx_nxt;
            r_tx_par   <= w_tx_par_nxt;
            r_tx_line  <= w_tx_line_nxt;
        end
    end

    always_comb begin
        w_tx_state_nxt = r_tx_state;
        w_tx_shift_nxt = r_tx_shift;
        w_tx_ticks_nxt = w_tx_tick ? r_tx_ticks + 4'd1 : r_tx_ticks;
        w_tx_idx_nxt   = r_tx_idx;
        w_tx_par_nxt   = r_tx_par;
        w_tx_line_nxt  = 1'b1;
        w_tx_clear     = 1'b0;
        w_tx_bit_end   = w_tx_tick && (r_tx_ticks == c_LAST_TICK);

        case (r_tx_state)
            TX_IDLE: begin
                if (i_Tx_Valid) begin
                    w_tx_state_nxt = TX_START;
                    w_tx_shift_nxt = i_Tx_Data;
                    w_tx_par_nxt   = parity_bit(^i_Tx_Data, PARITY);
                    w_tx_ticks_nxt = '0;
                    w_tx_clear     = 1'b1;
                end
            end
            TX_START: begin
                if (w_tx_bit_end) begin
                    w_tx_state_nxt = TX_DATA;
                    w_tx_idx_nxt   = '0;
                end
            end
            TX_DATA: begin
                if (w_tx_bit_end) begin
                    w_tx_shift_nxt = r_tx_shift >> 1;
                    if (r_tx_idx == c_LAST_DATA) begin
                        w_tx_state_nxt = c_HAS_PARITY ? TX_PARITY : TX_STOP;
                        w_tx_idx_nxt   = '0;
                    end else begin
                        w_tx_idx_nxt   = r_tx_idx + 4'd1;
                    end
                end
            end
            TX_PARITY: begin
                if (w_tx_bit_end) begin
                    w_tx_state_nxt = TX_STOP;
                    w_tx_idx_nxt   = '0;
                end
            end
            TX_STOP: begin
                if (w_tx_bit_end) begin
                    if (r_tx_idx == c_LAST_STOP) begin
                        w_tx_state_nxt = TX_IDLE;
                    end else begin
                        w_tx_idx_nxt   = r_tx_idx + 4'd1;
                    end
                end
            end
            default: w_tx_state_nxt = TX_IDLE;
        endcase

        // Line level is decoded from the next state so o_Tx is a clean flop.
        case (w_tx_state_nxt)
            TX_START:  w_tx_line_nxt = 1'b0;
            TX_DATA:   w_tx_line_nxt = w_tx_shift_nxt[0];
            TX_PARITY: w_tx_line_nxt = w_tx_par_nxt;
            default:   w_tx_line_nxt = 1'b1;
        endcase
    end

    assign o_Tx       = r_tx_line;
    assign o_Tx_Ready = (r_tx_state == TX_IDLE);

    // ---------------- receiver ----------------
    logic                 r_rx_meta, r_rx_sync, r_rx_armed;
    logic [1:0]           r_rx_fill;
    rx_state_t            r_rx_state,   w_rx_state_nxt;
    logic [DATA_BITS-1:0] r_rx_shift,   w_rx_shift_nxt;
    logic [3:0]           r_rx_ticks,   w_rx_ticks_nxt;
    logic [3:0]           r_rx_idx,     w_rx_idx_nxt;
    logic                 r_rx_par_bit, w_rx_par_bit_nxt;
    logic [DATA_BITS-1:0] r_rx_data,    w_rx_data_nxt;
    logic                 r_rx_valid,   w_rx_valid_nxt;
    logic                 r_par_err,    w_par_err_nxt;
    logic                 r_frm_err,    w_frm_err_nxt;
    logic                 w_rx_tick, w_rx_sample;

    uart_baud_tick #(.DIV(c_DIV)) u_rx_tick (
        .clk     (i_Clk),
        .rst     (i_Rst),
        .i_clear (1'b0),
        .o_tick  (w_rx_tick)
    );

    // Arm only after a genuine high has passed through the synchroniser,
    // so a line held low across reset is never mistaken for a start bit.
    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_fill  <= 2'b00;
            r_rx_armed <= 1'b0;
        end else begin
            r_rx_meta  <= i_Rx;
            r_rx_sync  <= r_rx_meta;
            r_rx_fill  <= {r_rx_fill[0], 1'b1};
            if (r_rx_fill[1] && r_rx_sync) begin
                r_rx_armed <= 1'b1;
            end
        end
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            r_rx_state   <= RX_IDLE;
            r_rx_shift   <= '0;
            r_rx_ticks   <= '0;
            r_rx_idx     <= '0;
            r_rx_par_bit <= 1'b0;
            r_rx_data    <= '0;
            r_rx_valid   <= 1'b0;
            r_par_err    <= 1'b0;
            r_frm_err    <= 1'b0;
        end else begin
            r_rx_state   <= w_rx_state_nxt;
            r_rx_shift   <= w_rx_shift_nxt;
            r_rx_ticks   <= w_rx_ticks_nxt;
            r_rx_idx     <= w_rx_idx_nxt;
            r_rx_par_bit <= w_rx_par_bit_nxt;
            r_rx_data    <= w_rx_data_nxt;
            r_rx_valid   <= w_rx_valid_nxt;
            r_par_err    <= w_par_err_nxt;
            r_frm_err    <= w_frm_err_nxt;
        end
    end

    always_comb begin
        w_rx_state_nxt   = r_rx_state;
        w_rx_shift_nxt   = r_rx_shift;
        w_rx_ticks_nxt   = w_rx_tick ? r_rx_ticks + 4'd1 : r_rx_ticks;
        w_rx_idx_nxt     = r_rx_idx;
        w_rx_par_bit_nxt = r_rx_par_bit;
        w_rx_data_nxt    = r_rx_data;
        w_rx_valid_nxt   = 1'b0;
        w_par_err_nxt    = r_par_err;
        w_frm_err_nxt    = r_frm_err;
        w_rx_sample      = w_rx_tick && (r_rx_ticks == c_LAST_TICK);

        case (r_rx_state)
            RX_IDLE: begin
                w_rx_ticks_nxt = '0;
                if (r_rx_armed && !r_rx_sync) begin
                    w_rx_state_nxt = RX_START;
                end
            end
            RX_START: begin
                if (w_rx_tick && (r_rx_ticks == c_MID_TICK)) begin
                    w_rx_ticks_nxt = '0;
                    w_rx_idx_nxt   = '0;
                    w_rx_state_nxt = r_rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (w_rx_sample) begin
                    w_rx_shift_nxt = {r_rx_sync, r_rx_shift[DATA_BITS-1:1]};
                    if (r_rx_idx == c_LAST_DATA) begin
                        w_rx_state_nxt = c_HAS_PARITY ? RX_PARITY : RX_STOP;
                    end else begin
                        w_rx_idx_nxt   = r_rx_idx + 4'd1;
                    end
                end
            end
            RX_PARITY: begin
                if (w_rx_sample) begin
                    w_rx_par_bit_nxt = r_rx_sync;
                    w_rx_state_nxt   = RX_STOP;
                end
            end
            RX_STOP: begin
                if (w_rx_sample) begin
                    w_rx_valid_nxt = 1'b1;
                    w_rx_data_nxt  = r_rx_shift;
                    w_par_err_nxt  = c_HAS_PARITY &&
                                     (r_rx_par_bit != parity_bit(^r_rx_shift, PARITY));
                    w_frm_err_nxt  = !r_rx_sync;
                    w_rx_state_nxt = r_rx_sync ? RX_IDLE : RX_WAIT_HIGH;
                end
            end
            RX_WAIT_HIGH: begin
                if (r_rx_sync) begin
                    w_rx_state_nxt = RX_IDLE;
                end
            end
            default: w_rx_state_nxt = RX_IDLE;
        endcase
    end

    assign o_Rx_Data    = r_rx_data;
    assign o_Rx_Valid   = r_rx_valid;
    assign o_Parity_Err = r_par_err;
    assign o_Frame_Err  = r_frm_err;

endmodule

`default_nettype wire

// File: tb/tb_uart_core.sv
// ============================================================
// Module   : tb_uart_core
// Brief    : Scoreboard bench for uart_core in 8N1, 8E1 and 8N2.
// Revision : 1.0 - initial release
// ============================================================
`default_nettype none

module tb_uart_core;

    localparam int c_CLK  = 1600000;
    localparam int c_BAUD = 10000;
    localparam int c_BIT  = 160;

    typedef struct packed {
        logic [7:0] data;
        logic       perr;
        logic       ferr;
    } rx_rec_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, rx_drive, loop_en;

    logic [7:0] n1_tx_data, e1_tx_data, n2_tx_data;
    logic       n1_tx_valid, e1_tx_valid, n2_tx_valid;
    logic       n1_tx_ready, e1_tx_ready, n2_tx_ready;
    logic       n1_tx, e1_tx, n2_tx, e1_rx;
    logic [7:0] n1_rx_data, e1_rx_data, n2_rx_data;
    logic       n1_rx_valid, e1_rx_valid, n2_rx_valid;
    logic       n1_perr, e1_perr, n2_perr;
    logic       n1_ferr, e1_ferr, n2_ferr;

    assign e1_rx = loop_en ? e1_tx : rx_drive;

    uart_core #(.CLOCK_RATE(c_CLK), .BAUD_RATE(c_BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) u_n1 (
        .i_Clk(clk), .i_Rst(rst), .i_Tx_Data(n1_tx_data), .i_Tx_Valid(n1_tx_valid),
        .o_Tx_Ready(n1_tx_ready), .o_Tx(n1_tx), .i_Rx(rx_drive), .o_Rx_Data(n1_rx_data),
        .o_Rx_Valid(n1_rx_valid), .o_Parity_Err(n1_perr), .o_Frame_Err(n1_ferr));

    uart_core #(.CLOCK_RATE(c_CLK), .BAUD_RATE(c_BAUD), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) u_e1 (
        .i_Clk(clk), .i_Rst(rst), .i_Tx_Data(e1_tx_data), .i_Tx_Valid(e1_tx_valid),
        .o_Tx_Ready(e1_tx_ready), .o_Tx(e1_tx), .i_Rx(e1_rx), .o_Rx_Data(e1_rx_data),
        .o_Rx_Valid(e1_rx_valid), .o_Parity_Err(e1_perr), .o_Frame_Err(e1_ferr));

    uart_core #(.CLOCK_RATE(c_CLK), .BAUD_RATE(c_BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(2)) u_n2 (
        .i_Clk(clk), .i_Rst(rst), .i_Tx_Data(n2_tx_data), .i_Tx_Valid(n2_tx_valid),
        .o_Tx_Ready(n2_tx_ready), .o_Tx(n2_tx), .i_Rx(rx_drive), .o_Rx_Data(n2_rx_data),
        .o_Rx_Valid(n2_rx_valid), .o_Parity_Err(n2_perr), .o_Frame_Err(n2_ferr));

    rx_rec_t exp_n1[$], got_n1[$], exp_e1[$], got_e1[$], got_n2[$];
    logic    exp_bits[$];
    int      n_cmp = 0;
    int      n_err = 0;

    always @(negedge clk) begin
        if (n1_rx_valid === 1'b1) got_n1.push_back({n1_rx_data, n1_perr, n1_ferr});
        if (e1_rx_valid === 1'b1) got_e1.push_back({e1_rx_data, e1_perr, e1_ferr});
        if (n2_rx_valid === 1'b1) got_n2.push_back({n2_rx_data, n2_perr, n2_ferr});
    end

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic drive_rx_frame(input logic [7:0] data, input bit has_par, input logic par,
                                  input logic stop_val, input int stop_cycles);
        rx_drive = 1'b0;
        step(c_BIT);
        for (int i = 0; i < 8; i++) begin
            rx_drive = data[i];
            step(c_BIT);
        end
        if (has_par) begin
            rx_drive = par;
            step(c_BIT);
        end
        rx_drive = stop_val;
        step(stop_cycles);
        rx_drive = 1'b1;
    endtask

    task automatic wait_got(input int sel, input int budget, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            if ((sel == 0 && got_n1.size() > 0) || (sel == 1 && got_e1.size() > 0)) begin
                ok = 1'b1;
                break;
            end
            step(1);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1; rx_drive = 1'b0; loop_en = 1'b0;
        n1_tx_valid = 1'b0; e1_tx_valid = 1'b0; n2_tx_valid = 1'b0;
        n1_tx_data = '0; e1_tx_data = '0; n2_tx_data = '0;
        step(3);
        n_cmp++;
        if ({n1_tx, n1_tx_ready, n1_rx_valid, n1_rx_data, n1_perr, n1_ferr} !== 13'b1_1_0_00000000_0_0) begin
            n_err++;
            $display("FAIL reset_n1: got tx=%b rdy=%b vld=%b data=%h perr=%b ferr=%b want 1 1 0 00 0 0",
                     n1_tx, n1_tx_ready, n1_rx_valid, n1_rx_data, n1_perr, n1_ferr);
        end
        n_cmp++;
        if ({e1_tx, e1_tx_ready, e1_rx_valid, e1_rx_data, e1_perr, e1_ferr} !== 13'b1_1_0_00000000_0_0) begin
            n_err++;
            $display("FAIL reset_e1: got tx=%b rdy=%b vld=%b data=%h perr=%b ferr=%b want 1 1 0 00 0 0",
                     e1_tx, e1_tx_ready, e1_rx_valid, e1_rx_data, e1_perr, e1_ferr);
        end
        rst = 1'b0;
        got_n1.delete();
        step(1700);
        n_cmp++;
        if (got_n1.size() !== 0) begin
            n_err++;
            $display("FAIL reset_rx_held_low: got %0d strobes want 0", got_n1.size());
        end
        rx_drive = 1'b1;
        step(40);
    endtask

    task automatic test_tx_8n1;
        logic [7:0] data;
        logic       exp;
        int         first_bad, bad_ready;
        logic       bad_val;
        data = 8'hA5;
        exp_bits.delete();
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(data[i]);
        exp_bits.push_back(1'b1);
        n_cmp++;
        if (n1_tx_ready !== 1'b1) begin
            n_err++;
            $display("FAIL tx_ready_idle: got %b want 1", n1_tx_ready);
        end
        n1_tx_data = data; n1_tx_valid = 1'b1;
        step(1);
        n1_tx_valid = 1'b0;
        bad_ready = 0;
        for (int b = 0; b < 10; b++) begin
            exp = exp_bits.pop_front();
            first_bad = -1; bad_val = 1'bx;
            for (int c = 0; c < c_BIT; c++) begin
                if (n1_tx !== exp && first_bad < 0) begin first_bad = c; bad_val = n1_tx; end
                if (n1_tx_ready !== 1'b0) bad_ready++;
                if (b == 3 && c == 50) begin n1_tx_data = 8'h00; n1_tx_valid = 1'b1; end
                if (b == 3 && c == 60) n1_tx_valid = 1'b0;
                step(1);
            end
            n_cmp++;
            if (first_bad >= 0) begin
                n_err++;
                $display("FAIL tx_8n1_bit%0d: cycle %0d got %b want %b", b, first_bad, bad_val, exp);
            end
        end
        n_cmp++;
        if (bad_ready != 0) begin
            n_err++;
            $display("FAIL tx_ready_busy: got %0d high cycles want 0", bad_ready);
        end
        n_cmp++;
        if (n1_tx_ready !== 1'b1 || n1_tx !== 1'b1) begin
            n_err++;
            $display("FAIL tx_ready_return: got rdy=%b tx=%b want 1 1", n1_tx_ready, n1_tx);
        end
        step(20);
    endtask

    task automatic test_loopback_even;
        logic [7:0] data;
        rx_rec_t    e, g;
        bit         ok;
        data = 8'h3C;
        got_e1.delete();
        loop_en = 1'b1;
        exp_e1.push_back({data, 1'b0, 1'b0});
        n_cmp++;
        if (e1_tx_ready !== 1'b1) begin
            n_err++;
            $display("FAIL loop_ready: got %b want 1", e1_tx_ready);
        end
        e1_tx_data = data; e1_tx_valid = 1'b1;
        step(1);
        e1_tx_valid = 1'b0;
        step(9 * c_BIT + 80);
        n_cmp++;
        if (e1_tx !== ^data) begin
            n_err++;
            $display("FAIL loop_parity_bit: got %b want %b", e1_tx, ^data);
        end
        wait_got(1, 1000, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL loop_timeout: got no strobe want 1");
        end else begin
            e = exp_e1.pop_front();
            g = got_e1.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL loop_rx: got data=%h perr=%b ferr=%b want data=%h perr=%b ferr=%b",
                         g.data, g.perr, g.ferr, e.data, e.perr, e.ferr);
            end
        end
        step(400);
        n_cmp++;
        if (got_e1.size() !== 0 || e1_rx_data !== data) begin
            n_err++;
            $display("FAIL loop_single_hold: got extra=%0d data=%h want 0 %h", got_e1.size(), e1_rx_data, data);
        end
        loop_en = 1'b0;
        exp_e1.delete();
        step(20);
    endtask

    task automatic test_parity_error;
        logic [7:0] data;
        logic       par;
        rx_rec_t    e, g;
        bit         ok;
        data = 8'h01; par = 1'b0;
        got_e1.delete();
        exp_e1.push_back({data, ((^data) != par), 1'b0});
        drive_rx_frame(data, 1'b1, par, 1'b1, c_BIT);
        wait_got(1, 400, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL parity_timeout: got no strobe want 1");
        end else begin
            e = exp_e1.pop_front();
            g = got_e1.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL parity_err: got data=%h perr=%b ferr=%b want data=%h perr=%b ferr=%b",
                         g.data, g.perr, g.ferr, e.data, e.perr, e.ferr);
            end
        end
        exp_e1.delete();
        step(300);
    endtask

    task automatic test_frame_error;
        rx_rec_t e, g;
        bit      ok;
        got_n1.delete();
        exp_n1.push_back({8'h55, 1'b0, 1'b1});
        drive_rx_frame(8'h55, 1'b0, 1'b0, 1'b0, 400);
        wait_got(0, 20, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL frame_timeout: got no strobe want 1");
        end else begin
            e = exp_n1.pop_front();
            g = got_n1.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL frame_err: got data=%h perr=%b ferr=%b want data=%h perr=%b ferr=%b",
                         g.data, g.perr, g.ferr, e.data, e.perr, e.ferr);
            end
        end
        step(1800);
        n_cmp++;
        if (got_n1.size() !== 0 || n1_ferr !== 1'b1) begin
            n_err++;
            $display("FAIL frame_rearm: got extra=%0d ferr=%b want 0 1", got_n1.size(), n1_ferr);
        end
        exp_n1.delete();
        exp_n1.push_back({8'h5A, 1'b0, 1'b0});
        drive_rx_frame(8'h5A, 1'b0, 1'b0, 1'b1, c_BIT);
        wait_got(0, 400, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL frame_recover_timeout: got no strobe want 1");
        end else begin
            e = exp_n1.pop_front();
            g = got_n1.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL frame_recover: got data=%h perr=%b ferr=%b want data=%h perr=%b ferr=%b",
                         g.data, g.perr, g.ferr, e.data, e.perr, e.ferr);
            end
        end
        exp_n1.delete();
        step(200);
    endtask

    task automatic test_glitch;
        rx_rec_t e, g;
        bit      ok;
        got_n1.delete();
        rx_drive = 1'b0;
        step(50);
        rx_drive = 1'b1;
        step(1800);
        n_cmp++;
        if (got_n1.size() !== 0) begin
            n_err++;
            $display("FAIL glitch_ignored: got %0d strobes want 0", got_n1.size());
        end
        got_n1.delete();
        exp_n1.push_back({8'h81, 1'b0, 1'b0});
        drive_rx_frame(8'h81, 1'b0, 1'b0, 1'b1, c_BIT);
        wait_got(0, 400, ok);
        n_cmp++;
        if (!ok) begin
            n_err++;
            $display("FAIL glitch_frame_timeout: got no strobe want 1");
        end else begin
            e = exp_n1.pop_front();
            g = got_n1.pop_front();
            n_cmp++;
            if (g !== e) begin
                n_err++;
                $display("FAIL glitch_frame: got data=%h perr=%b ferr=%b want data=%h perr=%b ferr=%b",
                         g.data, g.perr, g.ferr, e.data, e.perr, e.ferr);
            end
        end
        exp_n1.delete();
        step(200);
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] data;
        logic       exp;
        int         first_bad, bad_ready;
        logic       bad_val;
        got_n2.delete();
        n2_tx_data = 8'h00; n2_tx_valid = 1'b1;
        step(1);
        n2_tx_valid = 1'b0;
        step(4 * c_BIT + 60);
        n_cmp++;
        if (n2_tx !== 1'b0 || n2_tx_ready !== 1'b0) begin
            n_err++;
            $display("FAIL n2_mid_bit3: got tx=%b rdy=%b want 0 0", n2_tx, n2_tx_ready);
        end
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        n_cmp++;
        if (n2_tx !== 1'b1 || n2_tx_ready !== 1'b1) begin
            n_err++;
            $display("FAIL n2_reset_abort: got tx=%b rdy=%b want 1 1", n2_tx, n2_tx_ready);
        end
        step(10);
        data = 8'hFF;
        exp_bits.delete();
        exp_bits.push_back(1'b0);
        for (int i = 0; i < 8; i++) exp_bits.push_back(data[i]);
        exp_bits.push_back(1'b1);
        exp_bits.push_back(1'b1);
        n2_tx_data = data; n2_tx_valid = 1'b1;
        step(1);
        n2_tx_valid = 1'b0;
        bad_ready = 0;
        for (int b = 0; b < 11; b++) begin
            exp = exp_bits.pop_front();
            first_bad = -1; bad_val = 1'bx;
            for (int c = 0; c < c_BIT; c++) begin
                if (n2_tx !== exp && first_bad < 0) begin first_bad = c; bad_val = n2_tx; end
                if (n2_tx_ready !== 1'b0) bad_ready++;
                step(1);
            end
            n_cmp++;
            if (first_bad >= 0) begin
                n_err++;
                $display("FAIL tx_8n2_bit%0d: cycle %0d got %b want %b", b, first_bad, bad_val, exp);
            end
        end
        n_cmp++;
        if (bad_ready != 0 || n2_tx_ready !== 1'b1) begin
            n_err++;
            $display("FAIL tx_8n2_ready: got busy_high=%0d end=%b want 0 1", bad_ready, n2_tx_ready);
        end
        n_cmp++;
        if (got_n2.size() !== 0) begin
            n_err++;
            $display("FAIL n2_no_rx_strobe: got %0d want 0", got_n2.size());
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_tx_8n1();
        test_loopback_even();
        test_parity_error();
        test_frame_error();
        test_glitch();
        test_reset_mid_frame();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
